// File: rtl/allpass_pkg.sv
// allpass_pkg: shared constants and helpers for the allpass cascade.
//   GAIN_ONE      unity gain for the default fraction width
//   wide_t        wide signed scratch type used for saturation
//   gain_one()    unity gain (2^frac) for an arbitrary fraction width
//   gain_addr()   coefficient address of the output gain register (= n_stages)
//   sat_to_width  clamp a wide signed value into a w-bit signed range
package allpass_pkg;

  localparam int FRAC_DEFAULT = 10;
  localparam int GAIN_ONE     = 1 << FRAC_DEFAULT;

  // Every intermediate product/sum in the cascade must fit in this width
  // (WIDTH + CW + 3 bits at most).
  localparam int SAT_W = 128;
  typedef logic signed [SAT_W-1:0] wide_t;

  function automatic int gain_one(input int frac);
    return 1 << frac;
  endfunction

  // The gain register sits directly above the last stage coefficient.
  function automatic int gain_addr(input int n_stages);
    return n_stages;
  endfunction

  // Clamp to [-2^(w-1), 2^(w-1)-1]; the caller truncates the result to w bits.
  function automatic wide_t sat_to_width(input wide_t v, input int w);
    wide_t max_v;
    wide_t min_v;
    max_v = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    min_v = ~max_v;
    if (v > max_v) return max_v;
    if (v < min_v) return min_v;
    return v;
  endfunction

endpackage

// File: rtl/allpass_cascade_param_stage.sv
// allpass_stage: one first-order allpass section.
//   y = sat( (a * (s - y_prev)) >>> FRAC + x_prev ), state advances only on valid.
// Ports:
//   clk          clock, rising edge
//   rst_ni       synchronous active-low reset
//   valid_i      s_i carries a sample this cycle
//   s_i          signed input sample
//   approx_en_i  zero the low APPROX_BITS of the difference before multiplying
//   coef_i       signed Q1.(CW-1) coefficient
//   valid_o      y_o carries a new sample (valid_i delayed one cycle)
//   y_o          signed section output
module allpass_stage
  import allpass_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int CW          = 11,
  parameter int FRAC        = 10,
  parameter int APPROX_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  input  logic signed [WIDTH-1:0] s_i,
  input  logic                    approx_en_i,
  input  logic signed [CW-1:0]    coef_i,
  output logic                    valid_o,
  output logic signed [WIDTH-1:0] y_o
);

  localparam int PW = WIDTH + CW + 1;  // full product width
  localparam logic [WIDTH:0] KEEP_MASK = {(WIDTH + 1){1'b1}} << APPROX_BITS;

  logic signed [WIDTH-1:0] x_prev_q, x_prev_d;
  // y_q is both the feedback state y_prev and the stage output register.
  logic signed [WIDTH-1:0] y_q, y_d, y_new;
  logic                    valid_q;

  logic signed [WIDTH:0] diff, diff_m;
  logic signed [PW-1:0]  prod, prod_sh;
  logic signed [PW:0]    sum;

  always_comb begin
    diff    = {s_i[WIDTH-1], s_i} - {y_q[WIDTH-1], y_q};
    diff_m  = approx_en_i ? (diff & KEEP_MASK) : diff;
    // Operands pre-extended to the product width, so the low PW bits are exact.
    prod    = {{(WIDTH + 1){coef_i[CW-1]}}, coef_i} * {{CW{diff_m[WIDTH]}}, diff_m};
    prod_sh = prod >>> FRAC;
    sum     = {prod_sh[PW-1], prod_sh} + {{(PW + 1 - WIDTH){x_prev_q[WIDTH-1]}}, x_prev_q};
    y_new   = WIDTH'(sat_to_width(wide_t'(sum), WIDTH));
    y_d      = valid_i ? y_new : y_q;
    x_prev_d = valid_i ? s_i : x_prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      x_prev_q <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
    end else begin
      x_prev_q <= x_prev_d;
      y_q      <= y_d;
      valid_q  <= valid_i;
    end
  end

  assign valid_o = valid_q;
  assign y_o     = y_q;

endmodule

// File: rtl/allpass_cascade_param.sv
// allpass_cascade_param: N_STAGES allpass sections followed by a saturating
// output gain, with a run-time writable coefficient/gain register file.
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-low reset
//   in_valid   x_in carries a sample
//   x_in       signed input sample
//   approx_en  approximate multiply in every section
//   coef_we    coefficient write strobe
//   coef_addr  0..N_STAGES-1 stage coefficient, N_STAGES gain, others ignored
//   coef_data  signed coefficient / gain value
//   out_valid  y_out carries a new sample (in_valid delayed N_STAGES+1)
//   y_out      signed filtered sample
module allpass_cascade_param
  import allpass_pkg::*;
#(
  parameter int N_STAGES    = 6,
  parameter int WIDTH       = 32,
  parameter int CW          = 11,
  parameter int FRAC        = FRAC_DEFAULT,
  parameter int APPROX_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic                    approx_en,
  input  logic                    coef_we,
  input  logic [4:0]              coef_addr,
  input  logic signed [CW-1:0]    coef_data,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] y_out
);

  // The gain register is one bit wider than a coefficient so that the
  // reset value 1.0 (2^FRAC) is representable; writes are sign-extended.
  localparam int GW = CW + 1;
  localparam int OW = WIDTH + GW;
  localparam logic [4:0]           GAIN_ADDR = 5'(gain_addr(N_STAGES));
  localparam logic signed [GW-1:0] GAIN_RST  = GW'(gain_one(FRAC));

  logic signed [WIDTH-1:0] stage_y [N_STAGES+1];
  logic                    stage_v [N_STAGES+1];

  assign stage_y[0] = x_in;
  assign stage_v[0] = in_valid;

  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
    logic signed [CW-1:0] coef_q, coef_d;

    always_comb begin
      coef_d = coef_q;
      if (coef_we && coef_addr == 5'(gi)) coef_d = coef_data;
    end

    always_ff @(posedge clk) begin
      if (!reset) coef_q <= '0;
      else        coef_q <= coef_d;
    end

    allpass_stage #(
      .WIDTH      (WIDTH),
      .CW         (CW),
      .FRAC       (FRAC),
      .APPROX_BITS(APPROX_BITS)
    ) u_stage (
      .clk        (clk),
      .rst_ni     (reset),
      .valid_i    (stage_v[gi]),
      .s_i        (stage_y[gi]),
      .approx_en_i(approx_en),
      .coef_i     (coef_q),
      .valid_o    (stage_v[gi+1]),
      .y_o        (stage_y[gi+1])
    );
  end

  logic signed [GW-1:0]    gain_q, gain_d;
  logic signed [OW-1:0]    gprod, gprod_sh;
  logic signed [WIDTH-1:0] y_gain, y_out_q, y_out_d;
  logic                    out_valid_q;

  always_comb begin
    gain_d = gain_q;
    if (coef_we && coef_addr == GAIN_ADDR) gain_d = {coef_data[CW-1], coef_data};
    gprod    = {{GW{stage_y[N_STAGES][WIDTH-1]}}, stage_y[N_STAGES]}
             * {{WIDTH{gain_q[GW-1]}}, gain_q};
    gprod_sh = gprod >>> FRAC;
    y_gain   = WIDTH'(sat_to_width(wide_t'(gprod_sh), WIDTH));
    y_out_d  = stage_v[N_STAGES] ? y_gain : y_out_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gain_q      <= GAIN_RST;
      y_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      gain_q      <= gain_d;
      y_out_q     <= y_out_d;
      out_valid_q <= stage_v[N_STAGES];
    end
  end

  assign y_out     = y_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_allpass_cascade_param.sv
module tb_allpass_cascade_param;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic signed [31:0] x_in;
  logic               approx_en;
  logic               coef_we;
  logic [4:0]         coef_addr;
  logic signed [12:0] coef_data;
  logic               ov1, ov6;
  logic signed [31:0] y1, y6;

  int n_vec = 0;
  int n_err = 0;

  // Single-section instance and six-section instance share all stimulus.
  // CW=13 so that a gain of +2.0 (2048) is writable.
  allpass_cascade_param #(.N_STAGES(1), .WIDTH(32), .CW(13), .FRAC(10), .APPROX_BITS(4)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in), .approx_en(approx_en),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ov1), .y_out(y1)
  );

  allpass_cascade_param #(.N_STAGES(6), .WIDTH(32), .CW(13), .FRAC(10), .APPROX_BITS(4)) dut6 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in), .approx_en(approx_en),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(ov6), .y_out(y6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid  = 1'b0;
    x_in      = '0;
    approx_en = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic write_coef(input int addr, input int data);
    in_valid  = 1'b0;
    coef_we   = 1'b1;
    coef_addr = 5'(addr);
    coef_data = 13'(data);
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    tick();
    tick();
    n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL reset_ov1: got %0b expected 0", ov1); end
    n_vec++; if (y1 !== 32'sd0) begin n_err++; $display("FAIL reset_y1: got %0d expected 0", y1); end
    n_vec++; if (ov6 !== 1'b0) begin n_err++; $display("FAIL reset_ov6: got %0b expected 0", ov6); end
    n_vec++; if (y6 !== 32'sd0) begin n_err++; $display("FAIL reset_y6: got %0d expected 0", y6); end
    reset = 1'b1;
    $display("test_reset: done");
  endtask

  // All coefficients 0, gain 1.0: six one-sample delays.
  task automatic test_defaults();
    int first_c;
    logic ev;
    int exp_y;
    first_c = -1;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 10);
      x_in     = (c == 0) ? 32'sd1000 : 32'sd0;
      tick();
      ev = (c >= 6) && (c - 6 < 10);
      n_vec++;
      if (ov6 !== ev) begin n_err++; $display("FAIL defaults_ov6 c=%0d: got %0b expected %0b", c, ov6, ev); end
      if (ev) begin
        exp_y = (c - 6 == 6) ? 1000 : 0;
        n_vec++;
        if (y6 !== exp_y) begin n_err++; $display("FAIL defaults_y6 c=%0d: got %0d expected %0d", c, y6, exp_y); end
      end
      if (ov6 === 1'b1 && first_c < 0) first_c = c;
    end
    // in_valid first seen in cycle 0; output visible in cycle first_c+1.
    n_vec++;
    if (first_c + 1 !== 7) begin n_err++; $display("FAIL defaults_latency: got %0d expected 7", first_c + 1); end
    $display("test_defaults: done");
  endtask

  task automatic test_single();
    int exp_a [5] = '{512, 768, -384, 192, -96};
    logic ev;
    do_reset();
    write_coef(0, 512);
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 5);
      x_in     = (c == 0) ? 32'sd1024 : 32'sd0;
      tick();
      ev = (c >= 1) && (c - 1 < 5);
      n_vec++;
      if (ov1 !== ev) begin n_err++; $display("FAIL single_ov c=%0d: got %0b expected %0b", c, ov1, ev); end
      if (ev) begin
        n_vec++;
        if (y1 !== exp_a[c-1]) begin n_err++; $display("FAIL single_y c=%0d: got %0d expected %0d", c, y1, exp_a[c-1]); end
      end
    end
    $display("test_single: done");
  endtask

  task automatic test_valid_gaps();
    int exp_a [5] = '{512, 768, -384, 192, -96};
    logic hist [18];
    logic v, ev;
    int k;
    k = 0;
    do_reset();
    write_coef(0, 512);
    for (int c = 0; c < 18; c++) begin
      v        = (c % 3 == 0) && (c < 15);
      in_valid = v;
      // Junk on x_in during gaps must be ignored.
      x_in     = (c == 0) ? 32'sd1024 : (v ? 32'sd0 : 32'sd12345);
      hist[c]  = v;
      tick();
      ev = (c >= 1) ? hist[c-1] : 1'b0;
      n_vec++;
      if (ov1 !== ev) begin n_err++; $display("FAIL gaps_ov c=%0d: got %0b expected %0b", c, ov1, ev); end
      if (ev && k < 5) begin
        n_vec++;
        if (y1 !== exp_a[k]) begin n_err++; $display("FAIL gaps_y k=%0d: got %0d expected %0d", k, y1, exp_a[k]); end
        k++;
      end
    end
    n_vec++;
    if (k !== 5) begin n_err++; $display("FAIL gaps_count: got %0d expected 5", k); end
    $display("test_valid_gaps: done");
  endtask

  task automatic test_approx();
    // Approximate: d=15 -> 0; d=-15 -> -16 (low bits cleared of two's complement).
    int exp_on  [4] = '{0, 15, -8, 0};
    int exp_off [4] = '{7, 11, -6, 3};
    for (int mode = 0; mode < 2; mode++) begin
      do_reset();
      write_coef(0, 512);
      approx_en = (mode == 0);
      for (int c = 0; c < 5; c++) begin
        in_valid = (c < 4);
        x_in     = (c == 0) ? 32'sd15 : 32'sd0;
        tick();
        if (c >= 1) begin
          n_vec++;
          if (ov1 !== 1'b1) begin n_err++; $display("FAIL approx_ov mode=%0d c=%0d: got %0b expected 1", mode, c, ov1); end
          n_vec++;
          if (mode == 0 && y1 !== exp_on[c-1]) begin
            n_err++; $display("FAIL approx_on_y c=%0d: got %0d expected %0d", c, y1, exp_on[c-1]);
          end
          if (mode == 1 && y1 !== exp_off[c-1]) begin
            n_err++; $display("FAIL approx_off_y c=%0d: got %0d expected %0d", c, y1, exp_off[c-1]);
          end
        end
      end
    end
    approx_en = 1'b0;
    $display("test_approx: done");
  endtask

  task automatic test_saturation();
    int xs [8] = '{32'sh4000_0000, 32'shBFFF_FFFF, 0, 0, 0, 0, 0, 0};
    int exp_y;
    // dut1 gain = 2.0 (address 1); a_0 = 0 so the section delays by one sample.
    do_reset();
    write_coef(1, 2048);
    for (int c = 0; c < 4; c++) begin
      in_valid = (c < 3);
      x_in     = xs[c];
      tick();
      if (c >= 1) begin
        exp_y = (c - 1 == 1) ? 32'sh7FFF_FFFF : ((c - 1 == 2) ? 32'sh8000_0000 : 0);
        n_vec++;
        if (y1 !== exp_y) begin n_err++; $display("FAIL sat1_y c=%0d: got %0d expected %0d", c, y1, exp_y); end
      end
    end
    // dut6 gain = 2.0 (address 6); the same write is out of range for dut1.
    do_reset();
    write_coef(6, 2048);
    for (int c = 0; c < 15; c++) begin
      in_valid = (c < 8);
      x_in     = (c < 8) ? xs[c] : 0;
      tick();
      if (c >= 1 && c - 1 < 8) begin
        exp_y = (c - 1 >= 1) ? xs[c-2] : 0;
        n_vec++;
        if (y1 !== exp_y) begin n_err++; $display("FAIL sat_noop_y1 c=%0d: got %0d expected %0d", c, y1, exp_y); end
      end
      if (c >= 6 && c - 6 < 8) begin
        exp_y = (c - 6 == 6) ? 32'sh7FFF_FFFF : ((c - 6 == 7) ? 32'sh8000_0000 : 0);
        n_vec++;
        if (ov6 !== 1'b1) begin n_err++; $display("FAIL sat6_ov c=%0d: got %0b expected 1", c, ov6); end
        n_vec++;
        if (y6 !== exp_y) begin n_err++; $display("FAIL sat6_y c=%0d: got %0d expected %0d", c, y6, exp_y); end
      end
    end
    $display("test_saturation: done");
  endtask

  task automatic test_midstream();
    int exp_w [3] = '{0, 1024, -512};
    int exp_r [3] = '{0, 1024, 0};
    // Write a_0 in the same cycle as the first sample: that sample sees a_0=0.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      in_valid  = (c < 3);
      x_in      = (c == 0) ? 32'sd1024 : 32'sd0;
      coef_we   = (c == 0);
      coef_addr = 5'd0;
      coef_data = 13'sd512;
      tick();
      coef_we = 1'b0;
      if (c >= 1) begin
        n_vec++;
        if (y1 !== exp_w[c-1]) begin n_err++; $display("FAIL wr_same_cycle_y c=%0d: got %0d expected %0d", c, y1, exp_w[c-1]); end
      end
    end
    // Stream, then one reset cycle with a write pending: reset wins.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      x_in     = 1000 >> c;
      tick();
    end
    reset     = 1'b0;
    in_valid  = 1'b1;
    x_in      = 32'sd7;
    coef_we   = 1'b1;
    coef_addr = 5'd0;
    coef_data = 13'sd512;
    tick();
    n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL rst_mid_ov1: got %0b expected 0", ov1); end
    n_vec++; if (y1 !== 32'sd0) begin n_err++; $display("FAIL rst_mid_y1: got %0d expected 0", y1); end
    n_vec++; if (ov6 !== 1'b0) begin n_err++; $display("FAIL rst_mid_ov6: got %0b expected 0", ov6); end
    n_vec++; if (y6 !== 32'sd0) begin n_err++; $display("FAIL rst_mid_y6: got %0d expected 0", y6); end
    reset    = 1'b1;
    coef_we  = 1'b0;
    in_valid = 1'b0;
    x_in     = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_vec++;
      if (ov1 !== 1'b0 || ov6 !== 1'b0) begin
        n_err++; $display("FAIL rst_stale c=%0d: got ov1=%0b ov6=%0b expected 0 0", c, ov1, ov6);
      end
    end
    // Coefficient back to 0: the section is a plain one-sample delay again.
    for (int c = 0; c < 4; c++) begin
      in_valid = (c < 3);
      x_in     = (c == 0) ? 32'sd1024 : 32'sd0;
      tick();
      if (c >= 1) begin
        n_vec++;
        if (y1 !== exp_r[c-1]) begin n_err++; $display("FAIL rst_coef_cleared_y c=%0d: got %0d expected %0d", c, y1, exp_r[c-1]); end
      end
    end
    $display("test_midstream: done");
  endtask

  initial begin
    set_idle();
    reset = 1'b0;
    test_reset();
    test_defaults();
    test_single();
    test_valid_gaps();
    test_approx();
    test_saturation();
    test_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
